// File: rtl/mul_rr_arbiter.sv
// mul_rr_arbiter: two requesters share one 8x8 unsigned multiplier.
// A round-robin arbiter issues one operation per cycle into an operand
// register. The next cycle the product lands in the owner's response slot.
// Each requester may have only one operation in flight at a time.
module mul_rr_arbiter (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [7:0]  req0_a,
    input  logic [7:0]  req0_b,
    output logic        rsp0_valid,
    input  logic        rsp0_ready,
    output logic [15:0] rsp0_p,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [7:0]  req1_a,
    input  logic [7:0]  req1_b,
    output logic        rsp1_valid,
    input  logic        rsp1_ready,
    output logic [15:0] rsp1_p,
    output logic        busy
);

    logic [1:0]       inflight_q, inflight_d;
    logic             last_grant_q, last_grant_d;
    logic             op_valid_q, op_valid_d;
    logic             op_id_q, op_id_d;
    logic [7:0]       op_a_q, op_a_d;
    logic [7:0]       op_b_q, op_b_d;
    logic [1:0]       rsp_valid_q, rsp_valid_d;
    logic [1:0][15:0] rsp_p_q, rsp_p_d;

    logic [1:0]       eligible;
    logic [1:0]       grant;
    logic [1:0]       rsp_hs;
    logic [15:0]      product;

    // Round-robin grant: on a tie the requester not granted last wins; no grant in reset.
    always_comb begin
        eligible = {req1_valid & ~inflight_q[1], req0_valid & ~inflight_q[0]};
        grant    = 2'b00;
        if (!rst) begin
            if (eligible == 2'b11) begin
                grant = last_grant_q ? 2'b01 : 2'b10;
            end else begin
                grant = eligible;
            end
        end
    end

    // The single shared multiplier evaluates whatever sits in the operand register.
    assign product = 16'(op_a_q) * 16'(op_b_q);
    assign rsp_hs  = rsp_valid_q & {rsp1_ready, rsp0_ready};

    // Next-state: issue into the operand register, drain it into the owner's response slot.
    always_comb begin
        // NOTE: every _d takes a default before any condition, so no path leaves it unassigned and no latch is inferred.
        inflight_d   = (inflight_q | grant) & ~rsp_hs;
        last_grant_d = last_grant_q;
        op_valid_d   = |grant;
        op_id_d      = op_id_q;
        op_a_d       = op_a_q;
        op_b_d       = op_b_q;
        rsp_valid_d  = rsp_valid_q & ~rsp_hs;
        rsp_p_d      = rsp_p_q;

        if (|grant) begin
            last_grant_d = grant[1];
            op_id_d      = grant[1];
            op_a_d       = grant[1] ? req1_a : req0_a;
            op_b_d       = grant[1] ? req1_b : req0_b;
        end

        // The owner's slot is always free here because its inflight bit blocks re-issue.
        if (op_valid_q) begin
            rsp_valid_d[op_id_q] = 1'b1;
            rsp_p_d[op_id_q]     = product;
        end
    end

    // Control and response registers, synchronously reset.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments, so every register samples the values from before the edge.
        if (rst) begin
            inflight_q   <= 2'b00;
            last_grant_q <= 1'b1;
            op_valid_q   <= 1'b0;
            rsp_valid_q  <= 2'b00;
            rsp_p_q      <= '0;
        end else begin
            inflight_q   <= inflight_d;
            last_grant_q <= last_grant_d;
            op_valid_q   <= op_valid_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_p_q      <= rsp_p_d;
        end
    end

    // Operand data registers capture on issue only.
    always_ff @(posedge clk) begin
        // NOTE: these data-only registers are not reset; op_valid_q qualifies every use of them.
        op_id_q <= op_id_d;
        op_a_q  <= op_a_d;
        op_b_q  <= op_b_d;
    end

    assign req0_ready = grant[0];
    assign req1_ready = grant[1];
    assign rsp0_valid = rsp_valid_q[0];
    assign rsp1_valid = rsp_valid_q[1];
    assign rsp0_p     = rsp_p_q[0];
    assign rsp1_p     = rsp_p_q[1];
    assign busy       = |inflight_q;

endmodule

// File: tb/tb_mul_rr_arbiter.sv
// tb_mul_rr_arbiter: scenario tasks for the shared-multiplier arbiter.
// Expected products are pushed when an issue handshake is seen.
// Observed products are collected on response handshakes.
// Each task compares the collected products inline against the expected ones.
module tb_mul_rr_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0_valid, req1_valid;
    logic [7:0]  req0_a, req0_b, req1_a, req1_b;
    logic        rsp0_ready, rsp1_ready;
    logic        req0_ready, req1_ready;
    logic        rsp0_valid, rsp1_valid;
    logic [15:0] rsp0_p, rsp1_p;
    logic        busy;

    int          checks = 0;
    int          errors = 0;
    logic [15:0] exp_q0[$], exp_q1[$], got_q0[$], got_q1[$];
    int          grant_log[$];

    always #5 clk = ~clk;

    mul_rr_arbiter dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .rsp0_valid (rsp0_valid),
        .rsp0_ready (rsp0_ready),
        .rsp0_p     (rsp0_p),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .rsp1_valid (rsp1_valid),
        .rsp1_ready (rsp1_ready),
        .rsp1_p     (rsp1_p),
        .busy       (busy)
    );

    // Record handshakes due at the coming edge, then advance one cycle.
    task automatic step();
        #1;
        if (!rst) begin
            if (req0_valid && req0_ready) begin
                exp_q0.push_back(16'(req0_a) * 16'(req0_b));
                grant_log.push_back(0);
            end
            if (req1_valid && req1_ready) begin
                exp_q1.push_back(16'(req1_a) * 16'(req1_b));
                grant_log.push_back(1);
            end
            if (rsp0_valid && rsp0_ready) got_q0.push_back(rsp0_p);
            if (rsp1_valid && rsp1_ready) got_q1.push_back(rsp1_p);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; req0_valid = 1'b1; req1_valid = 1'b1; #1;
        checks++;
        if ({req1_ready, req0_ready} !== 2'b00) begin
            errors++; $display("FAIL reset_ready: got %b, expected 00", {req1_ready, req0_ready});
        end
        step();
        checks++;
        if ({rsp0_valid, rsp1_valid, busy} !== 3'b000) begin
            errors++; $display("FAIL reset_flags: got %b, expected 000", {rsp0_valid, rsp1_valid, busy});
        end
        checks++;
        if ({rsp0_p, rsp1_p} !== 32'h0) begin
            errors++; $display("FAIL reset_products: got %h %h, expected 0000 0000", rsp0_p, rsp1_p);
        end
        req0_valid = 1'b0; req1_valid = 1'b0; rst = 1'b0;
        step();
    endtask

    task automatic test_single_op();
        rsp0_ready = 1'b1; req0_valid = 1'b1; req0_a = 8'h0C; req0_b = 8'h0D; #1;
        checks++;
        if (req0_ready !== 1'b1) begin
            errors++; $display("FAIL single_grant: got %b, expected 1", req0_ready);
        end
        step();
        // Operands changed after the issue edge must not affect the product.
        req0_valid = 1'b0; req0_a = 8'hFF; req0_b = 8'hFF; #1;
        checks++;
        if ({rsp0_valid, busy} !== 2'b01) begin
            errors++; $display("FAIL single_stage1: got valid=%b busy=%b, expected 0 1", rsp0_valid, busy);
        end
        step();
        checks++;
        if ({rsp0_valid, rsp0_p} !== {1'b1, 16'h009C}) begin
            errors++; $display("FAIL single_rsp: got %b %h, expected 1 009c", rsp0_valid, rsp0_p);
        end
        step();
        checks++;
        if ({rsp0_valid, busy, rsp0_p} !== {2'b00, 16'h009C}) begin
            errors++; $display("FAIL single_after: got valid=%b busy=%b p=%h, expected 0 0 009c", rsp0_valid, busy, rsp0_p);
        end
        exp_q0.delete(); got_q0.delete();
        rsp0_ready = 1'b0;
    endtask

    task automatic test_tie();
        rst = 1'b1; step(); rst = 1'b0;
        rsp0_ready = 1'b1; rsp1_ready = 1'b1;
        req0_valid = 1'b1; req0_a = 8'hFF; req0_b = 8'hFF;
        req1_valid = 1'b1; req1_a = 8'h80; req1_b = 8'h02; #1;
        checks++;
        if ({req1_ready, req0_ready} !== 2'b01) begin
            errors++; $display("FAIL tie_first: got %b, expected 01", {req1_ready, req0_ready});
        end
        step();
        req0_valid = 1'b0; #1;
        checks++;
        if ({req1_ready, req0_ready} !== 2'b10) begin
            errors++; $display("FAIL tie_second: got %b, expected 10", {req1_ready, req0_ready});
        end
        step();
        req1_valid = 1'b0;
        checks++;
        if ({rsp0_valid, rsp0_p, rsp1_valid} !== {1'b1, 16'hFE01, 1'b0}) begin
            errors++; $display("FAIL tie_rsp0: got %b %h rsp1_valid=%b, expected 1 fe01 0", rsp0_valid, rsp0_p, rsp1_valid);
        end
        step();
        checks++;
        if ({rsp1_valid, rsp1_p, rsp0_valid} !== {1'b1, 16'h0100, 1'b0}) begin
            errors++; $display("FAIL tie_rsp1: got %b %h rsp0_valid=%b, expected 1 0100 0", rsp1_valid, rsp1_p, rsp0_valid);
        end
        step(); step();
        checks++;
        if (got_q0.size() != exp_q0.size() || got_q1.size() != exp_q1.size()) begin
            errors++; $display("FAIL tie_count: got %0d/%0d, expected %0d/%0d", got_q0.size(), got_q1.size(), exp_q0.size(), exp_q1.size());
        end
        foreach (got_q0[k]) if (k < exp_q0.size()) begin
            checks++;
            if (got_q0[k] !== exp_q0[k]) begin errors++; $display("FAIL tie_sb0[%0d]: got %h, expected %h", k, got_q0[k], exp_q0[k]); end
        end
        foreach (got_q1[k]) if (k < exp_q1.size()) begin
            checks++;
            if (got_q1[k] !== exp_q1[k]) begin errors++; $display("FAIL tie_sb1[%0d]: got %h, expected %h", k, got_q1[k], exp_q1[k]); end
        end
        exp_q0.delete(); exp_q1.delete(); got_q0.delete(); got_q1.delete();
    endtask

    task automatic test_backpressure();
        rsp0_ready = 1'b0; rsp1_ready = 1'b1;
        req0_valid = 1'b1; req0_a = 8'h10; req0_b = 8'h10; req1_valid = 1'b0; #1;
        checks++;
        if (req0_ready !== 1'b1) begin
            errors++; $display("FAIL bp_issue: got %b, expected 1", req0_ready);
        end
        step();
        req1_valid = 1'b1; req1_a = 8'h03; req1_b = 8'h05;
        for (int i = 0; i < 6; i++) begin
            #1;
            checks++;
            if (req0_ready !== 1'b0) begin
                errors++; $display("FAIL bp_ready0[%0d]: got %b, expected 0", i, req0_ready);
            end
            if (i >= 1) begin
                checks++;
                if ({rsp0_valid, rsp0_p} !== {1'b1, 16'h0100}) begin
                    errors++; $display("FAIL bp_hold[%0d]: got %b %h, expected 1 0100", i, rsp0_valid, rsp0_p);
                end
            end
            step();
        end
        rsp0_ready = 1'b1; req0_valid = 1'b0; req1_valid = 1'b0;
        repeat (6) step();
        checks++;
        if (exp_q1.size() == 0 || got_q1.size() != exp_q1.size() || got_q0.size() != exp_q0.size()) begin
            errors++; $display("FAIL bp_count: got %0d/%0d, expected %0d/%0d (req1 nonzero)", got_q0.size(), got_q1.size(), exp_q0.size(), exp_q1.size());
        end
        foreach (got_q0[k]) if (k < exp_q0.size()) begin
            checks++;
            if (got_q0[k] !== exp_q0[k]) begin errors++; $display("FAIL bp_sb0[%0d]: got %h, expected %h", k, got_q0[k], exp_q0[k]); end
        end
        foreach (got_q1[k]) if (k < exp_q1.size()) begin
            checks++;
            if (got_q1[k] !== exp_q1[k]) begin errors++; $display("FAIL bp_sb1[%0d]: got %h, expected %h", k, got_q1[k], exp_q1[k]); end
        end
        exp_q0.delete(); exp_q1.delete(); got_q0.delete(); got_q1.delete();
    endtask

    task automatic test_reset_midop();
        int seen = 0;
        rsp0_ready = 1'b1; rsp1_ready = 1'b1;
        req0_valid = 1'b0; req1_valid = 1'b1; req1_a = 8'h22; req1_b = 8'h33; #1;
        checks++;
        if (req1_ready !== 1'b1) begin
            errors++; $display("FAIL midop_issue: got %b, expected 1", req1_ready);
        end
        step();
        req1_valid = 1'b0; rst = 1'b1;
        step();
        checks++;
        if ({rsp0_valid, rsp1_valid, busy, req0_ready, req1_ready, rsp0_p, rsp1_p} !== 37'h0) begin
            errors++; $display("FAIL midop_outputs: got v=%b%b busy=%b rdy=%b%b p=%h %h, expected all zero",
                               rsp0_valid, rsp1_valid, busy, req0_ready, req1_ready, rsp0_p, rsp1_p);
        end
        rst = 1'b0;
        exp_q0.delete(); exp_q1.delete(); got_q0.delete(); got_q1.delete();
        repeat (5) begin
            if (rsp1_valid === 1'b1) seen++;
            step();
        end
        checks++;
        if (seen != 0) begin
            errors++; $display("FAIL midop_no_rsp: got %0d cycles with rsp1_valid, expected 0", seen);
        end
        req0_valid = 1'b1; req0_a = 8'h07; req0_b = 8'h09;
        req1_valid = 1'b1; req1_a = 8'h0B; req1_b = 8'h0D; #1;
        checks++;
        if ({req1_ready, req0_ready} !== 2'b01) begin
            errors++; $display("FAIL midop_tie: got %b, expected 01", {req1_ready, req0_ready});
        end
        step();
        req0_valid = 1'b0;
        step();
        req1_valid = 1'b0;
        repeat (5) step();
        checks++;
        if (got_q0.size() != exp_q0.size() || got_q1.size() != exp_q1.size()) begin
            errors++; $display("FAIL midop_count: got %0d/%0d, expected %0d/%0d", got_q0.size(), got_q1.size(), exp_q0.size(), exp_q1.size());
        end
        foreach (got_q0[k]) if (k < exp_q0.size()) begin
            checks++;
            if (got_q0[k] !== exp_q0[k]) begin errors++; $display("FAIL midop_sb0[%0d]: got %h, expected %h", k, got_q0[k], exp_q0[k]); end
        end
        foreach (got_q1[k]) if (k < exp_q1.size()) begin
            checks++;
            if (got_q1[k] !== exp_q1[k]) begin errors++; $display("FAIL midop_sb1[%0d]: got %h, expected %h", k, got_q1[k], exp_q1[k]); end
        end
        exp_q0.delete(); exp_q1.delete(); got_q0.delete(); got_q1.delete();
    endtask

    task automatic test_streaming();
        grant_log.delete();
        rsp0_ready = 1'b1; rsp1_ready = 1'b1;
        req0_valid = 1'b1; req0_a = 8'h00; req0_b = 8'hAB;
        req1_valid = 1'b1; req1_a = 8'h01; req1_b = 8'hAB;
        repeat (12) step();
        req0_valid = 1'b0; req1_valid = 1'b0;
        repeat (5) step();
        checks++;
        if (grant_log.size() < 6) begin
            errors++; $display("FAIL stream_grants: got %0d grants, expected at least 6", grant_log.size());
        end
        foreach (grant_log[k]) begin
            checks++;
            if (grant_log[k] != k % 2) begin
                errors++; $display("FAIL stream_order[%0d]: got %0d, expected %0d", k, grant_log[k], k % 2);
            end
        end
        checks++;
        if (got_q0.size() != exp_q0.size() || got_q1.size() != exp_q1.size()) begin
            errors++; $display("FAIL stream_count: got %0d/%0d, expected %0d/%0d", got_q0.size(), got_q1.size(), exp_q0.size(), exp_q1.size());
        end
        foreach (got_q0[k]) if (k < exp_q0.size()) begin
            checks++;
            if (got_q0[k] !== exp_q0[k]) begin errors++; $display("FAIL stream_sb0[%0d]: got %h, expected %h", k, got_q0[k], exp_q0[k]); end
        end
        foreach (got_q1[k]) if (k < exp_q1.size()) begin
            checks++;
            if (got_q1[k] !== exp_q1[k]) begin errors++; $display("FAIL stream_sb1[%0d]: got %h, expected %h", k, got_q1[k], exp_q1[k]); end
        end
        exp_q0.delete(); exp_q1.delete(); got_q0.delete(); got_q1.delete();
    endtask

    initial begin
        rst = 1'b1;
        req0_valid = 1'b0; req0_a = 8'h00; req0_b = 8'h00; rsp0_ready = 1'b0;
        req1_valid = 1'b0; req1_a = 8'h00; req1_b = 8'h00; rsp1_ready = 1'b0;
        test_reset();
        test_single_op();
        test_tie();
        test_backpressure();
        test_reset_midop();
        test_streaming();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
